// File: rtl/tree_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tree_noc_pkg
// Shared definitions for the tree-NoC router output-port arbiter:
//   - default packet width and requester/counter sizing
//   - requester port indices (parent, child1, child2)
//   - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package tree_noc_pkg;

    localparam int DEF_WIDTH_PACKET = 14;
    localparam int DEF_NUM_REQ      = 3;
    localparam int DEF_CNT_W        = 8;

    localparam logic [1:0] PORT_PARENT = 2'd0;
    localparam logic [1:0] PORT_CHILD1 = 2'd1;
    localparam logic [1:0] PORT_CHILD2 = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_e;

endpackage : tree_noc_pkg

// File: rtl/tree_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// tree_port_arbiter_if
// Bundles the request side (in_valid/in_data/in_ready), the output link
// (out_valid/out_data/out_ready/out_src) and the grant statistics of one
// router output port.
//   slave  : the arbiter (consumes requests, drives the output link)
//   master : the environment (drives requests, consumes the output link)
// -----------------------------------------------------------------------------
interface tree_port_arbiter_if
    import tree_noc_pkg::*;
#(
    parameter int WIDTH_packet = DEF_WIDTH_PACKET,
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int CNT_W        = DEF_CNT_W
);

    logic [NUM_REQ-1:0]                   in_valid;
    logic [NUM_REQ-1:0][WIDTH_packet-1:0] in_data;
    logic [NUM_REQ-1:0]                   in_ready;
    logic                                 out_valid;
    logic [WIDTH_packet-1:0]              out_data;
    logic                                 out_ready;
    logic [1:0]                           out_src;
    logic [NUM_REQ-1:0][CNT_W-1:0]        grant_cnt;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, grant_cnt
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, grant_cnt
    );

endinterface : tree_port_arbiter_if

// File: rtl/tree_port_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Purely combinational rotate-priority encoder. Scans the requests starting
// just after the last granted index, wrapping around, and reports the first
// active one.
//   req     : request vector, one bit per requester
//   last    : index granted most recently
//   gnt_idx : selected requester index (0 when none)
//   any     : at least one request is active
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         gnt_idx,
    output logic               any
);

    logic [1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest active request
    // after 'last' is the one left standing.
    always_comb begin
        gnt_idx = 2'd0;
        w_idx   = 2'd0;
        any     = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx   = 2'((int'(last) + k) % NUM_REQ);
            gnt_idx = req[w_idx] ? w_idx : gnt_idx;
        end
    end

endmodule : rr_select

// File: rtl/tree_port_arbiter.sv
// -----------------------------------------------------------------------------
// tree_port_arbiter
// Round-robin arbiter plus one-entry output register for one output link of a
// tree-NoC router node. Parent (0), child1 (1) and child2 (2) compete; one
// packet is accepted per handshake and held until downstream takes it.
// Back-to-back transfers run at one packet per cycle.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tree_port_arbiter_if.slave
//           in_valid/in_data in, in_ready out (one-hot or zero)
//           out_valid/out_data/out_src out, out_ready in
//           grant_cnt out, wrapping per-requester grant counters
// -----------------------------------------------------------------------------
module tree_port_arbiter
    import tree_noc_pkg::*;
#(
    parameter int WIDTH_packet = DEF_WIDTH_PACKET,
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tree_port_arbiter_if.slave   bus
);

    arb_state_e                    r_state;
    arb_state_e                    w_next_state;
    logic [WIDTH_packet-1:0]       r_out_data;
    logic [1:0]                    r_out_src;
    logic [1:0]                    r_last;
    logic [NUM_REQ-1:0][CNT_W-1:0] r_grant_cnt;

    logic [1:0]                    w_sel;
    logic                          w_any;
    logic                          w_load_en;
    logic                          w_load;
    logic [NUM_REQ-1:0]            w_in_ready;

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req     (bus.in_valid),
        .last    (r_last),
        .gnt_idx (w_sel),
        .any     (w_any)
    );

    // Load decision and in_ready. rst_n gating keeps in_ready low while the
    // block is held in reset even though the register reads as empty.
    always_comb begin
        w_load_en = (r_state == IDLE) || bus.out_ready;
        w_load    = rst_n && w_load_en && w_any;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_in_ready[i] = w_load && (w_sel == 2'(i));
        end
    end

    // Next-state logic: FULL stays FULL when a new packet reloads during the
    // output handshake, so there is no bubble between packets.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_next_state = FULL;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    w_next_state = w_any ? FULL : IDLE;
                end else begin
                    w_next_state = FULL;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output register and round-robin pointer; last starts at child2 so the
    // parent wins the first arbitration after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_src  <= PORT_PARENT;
            r_last     <= PORT_CHILD2;
        end else if (w_load) begin
            r_out_data <= bus.in_data[w_sel];
            r_out_src  <= w_sel;
            r_last     <= w_sel;
        end else begin
            r_out_data <= r_out_data;
            r_out_src  <= r_out_src;
            r_last     <= r_last;
        end
    end

    // Per-requester grant counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_load && (w_sel == 2'(i))) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + CNT_W'(1);
                end else begin
                    r_grant_cnt[i] <= r_grant_cnt[i];
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == FULL);
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.grant_cnt = r_grant_cnt;

endmodule : tree_port_arbiter

// File: tb/tb_tree_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tree_port_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model
// (held packet, last grant, grant counts) predicts every output each cycle;
// requesters tag packets with port and sequence number so delivery order and
// completeness are checked at the output link.
// -----------------------------------------------------------------------------
module tb_tree_port_arbiter;
    import tree_noc_pkg::*;

    localparam int W  = 14;
    localparam int N  = 3;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tree_port_arbiter_if #(.WIDTH_packet(W), .NUM_REQ(N), .CNT_W(CW)) ifc ();

    tree_port_arbiter #(.WIDTH_packet(W), .NUM_REQ(N), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_last;
    int           m_cnt [N];

    // scoreboard
    bit           sb_en = 1'b0;
    int           gen_seq [N];
    int           exp_seq [N];
    logic [N-1:0] last_rdy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_last  = 2;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endfunction

    // first valid requester after the last grant, wrapping; -1 when none
    function automatic int model_sel();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (ifc.in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        logic [N-1:0] r;
        int s;
        r = '0;
        s = model_sel();
        if (rst_n && (!m_valid || ifc.out_ready) && s >= 0) r[s] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int s;
            s = model_sel();
            if ((!m_valid || ifc.out_ready) && s >= 0) begin
                m_valid  = 1'b1;
                m_data   = ifc.in_data[s];
                m_src    = s;
                m_last   = s;
                m_cnt[s] = (m_cnt[s] + 1) % 256;
            end else if (m_valid && ifc.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // per-cycle compare of every output against the model
    always @(negedge clk) begin
        #3;
        check("in_ready", 32'(ifc.in_ready), 32'(model_rdy()));
        check("out_valid", 32'(ifc.out_valid), 32'(m_valid));
        check("out_data", 32'(ifc.out_data), 32'(m_data));
        check("out_src", 32'(ifc.out_src), m_src);
        for (int i = 0; i < N; i++) check("grant_cnt", 32'(ifc.grant_cnt[i]), m_cnt[i]);
        if (sb_en && ifc.out_valid && ifc.out_ready) begin
            int src;
            src = int'(ifc.out_src);
            check("sb_tag", 32'(ifc.out_data[13:12]), src);
            check("sb_seq", 32'(ifc.out_data[11:0]), exp_seq[src] & 32'hFFF);
            exp_seq[src]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int p, input logic [W-1:0] d);
        ifc.in_valid[p] = 1'b1;
        ifc.in_data[p]  = d;
    endtask

    // one cycle: capture in_ready before the edge, retire accepted requests
    task automatic cycle();
        #2;
        last_rdy = ifc.in_ready;
        @(negedge clk);
        #2;
        ifc.in_valid = ifc.in_valid & ~last_rdy;
    endtask

    task automatic drain();
        int g;
        ifc.out_ready = 1'b1;
        g = 0;
        while (g < 20 && (ifc.in_valid != '0 || ifc.out_valid)) begin
            cycle();
            g++;
        end
        check("drain_done", {ifc.in_valid, ifc.out_valid}, 32'd0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_grant_cnt", 32'(ifc.grant_cnt), 32'd0);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        #2;
    endtask

    initial begin
        int cnt0;
        int guard;
        model_reset();
        ifc.in_valid  = '0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        #2;

        // reset: request held during reset, port 0 wins first after release
        send(0, 14'h1A5);
        cycle();
        check("rst_no_ready", 32'(last_rdy), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("first_grant_p0", 32'(last_rdy), 32'b001);
        cycle();
        check("full_valid", 32'(ifc.out_valid), 32'd1);
        check("full_data_1A5", 32'(ifc.out_data), 32'h1A5);
        async_reset();
        send(1, 14'h2B4);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("post_rst_p1", 32'(last_rdy), 32'b010);
        check("post_rst_src1", 32'(ifc.out_src), 32'd1);
        check("post_rst_data", 32'(ifc.out_data), 32'h2B4);
        drain();

        // single requester on port 2
        send(2, 14'h0F0);
        cycle();
        check("single_rdy", 32'(last_rdy), 32'b100);
        check("single_data", 32'(ifc.out_data), 32'h0F0);
        check("single_src", 32'(ifc.out_src), 32'd2);
        check("single_cnt2", 32'(ifc.grant_cnt[2]), 32'd1);
        cycle();
        check("single_rdy_once", 32'(last_rdy), 32'd0);
        check("single_empty", 32'(ifc.out_valid), 32'd0);

        // all three continuously valid: 0,1,2,0,1,2 with no bubble
        for (int p = 0; p < N; p++) send(p, 14'(16 * p));
        for (int j = 0; j < 6; j++) begin
            cycle();
            check("rr_src", 32'(ifc.out_src), j % 3);
            check("rr_valid", 32'(ifc.out_valid), 32'd1);
            for (int p = 0; p < N; p++) if (!ifc.in_valid[p]) send(p, 14'(16 * p + j));
        end
        drain();

        // back-pressure holding 3FF, then release and same-cycle reload
        ifc.out_ready = 1'b0;
        send(2, 14'h3FF);
        cycle();
        send(0, 14'h055);
        send(1, 14'h123);
        for (int j = 0; j < 5; j++) begin
            cycle();
            check("bp_rdy", 32'(last_rdy), 32'd0);
            check("bp_data", 32'(ifc.out_data), 32'h3FF);
        end
        ifc.out_ready = 1'b1;
        cycle();
        check("bp_release_rdy", 32'(last_rdy), 32'b001);
        check("bp_next_data", 32'(ifc.out_data), 32'h055);
        check("bp_next_src", 32'(ifc.out_src), 32'd0);
        cycle();
        check("simul_rdy", 32'(last_rdy), 32'b010);
        check("simul_data", 32'(ifc.out_data), 32'h123);
        check("simul_full", 32'(ifc.out_valid), 32'd1);
        drain();

        // counter wrap on port 0
        async_reset();
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        cnt0  = 0;
        guard = 0;
        while (cnt0 < 256 && guard < 600) begin
            if (!ifc.in_valid[0]) send(0, 14'(cnt0));
            cycle();
            if (last_rdy[0]) cnt0++;
            if (cnt0 == 255 && last_rdy[0]) check("cnt_255", 32'(ifc.grant_cnt[0]), 32'd255);
            guard++;
        end
        check("wrap_grants", cnt0, 32'd256);
        check("wrap_cnt0", 32'(ifc.grant_cnt[0]), 32'd0);
        check("wrap_cnt1", 32'(ifc.grant_cnt[1]), 32'd0);
        check("wrap_cnt2", 32'(ifc.grant_cnt[2]), 32'd0);
        drain();

        // randomized traffic with tagged packets
        for (int p = 0; p < N; p++) begin
            gen_seq[p] = 0;
            exp_seq[p] = 0;
        end
        sb_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!ifc.in_valid[p] && $urandom_range(0, 99) < 60) begin
                    send(p, {2'(p), 12'(gen_seq[p])});
                    gen_seq[p]++;
                end
            end
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();
        for (int p = 0; p < N; p++) check("sb_all_delivered", exp_seq[p], gen_seq[p]);
        sb_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tree_port_arbiter
